// File: rtl/data_cache_pkg.sv
// Shared definitions for the direct-mapped write-back data cache:
// access codes, FSM encoding and store lane generation.
package data_cache_pkg;

    localparam int BLOCK_W = 128;

    localparam logic [3:0] IDLE_OP = 4'b0000;
    localparam logic [3:0] LB      = 4'b0001;
    localparam logic [3:0] LH      = 4'b0010;
    localparam logic [3:0] LW      = 4'b0011;
    localparam logic [3:0] LBU     = 4'b0100;
    localparam logic [3:0] LHU     = 4'b0101;
    localparam logic [3:0] SB      = 4'b1001;
    localparam logic [3:0] SH      = 4'b1010;
    localparam logic [3:0] SW      = 4'b1011;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WRITEBACK = 2'd1,
        ST_FETCH     = 2'd2,
        ST_REFILL    = 2'd3
    } state_t;

    typedef struct packed {
        logic [3:0]  mask;
        logic [31:0] data;
    } store_lanes_t;

    function automatic logic is_load(input logic [3:0] op);
        return (op == LB) || (op == LH) || (op == LW) || (op == LBU) || (op == LHU);
    endfunction

    function automatic logic is_store(input logic [3:0] op);
        return (op == SB) || (op == SH) || (op == SW);
    endfunction

    // Address bits below the access size are dropped, so stores never trap on misalignment.
    function automatic store_lanes_t store_lanes(input logic [3:0] op,
                                                 input logic [1:0] byte_off,
                                                 input logic [31:0] wdata);
        store_lanes_t s;
        s.mask = 4'b0000;
        s.data = 32'h0;
        case (op)
            SB: begin
                s.mask = 4'b0001 << byte_off;
                s.data = {24'h0, wdata[7:0]} << {byte_off, 3'b000};
            end
            SH: begin
                s.mask = byte_off[1] ? 4'b1100 : 4'b0011;
                s.data = byte_off[1] ? {wdata[15:0], 16'h0} : {16'h0, wdata[15:0]};
            end
            SW: begin
                s.mask = 4'b1111;
                s.data = wdata;
            end
            default: ;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/data_cache_store_merge.sv
// Combinational merge of one masked word into a 128-bit cache block.
module cache_store_merge
    import data_cache_pkg::*;
(
    input  logic [BLOCK_W-1:0] block_in,
    input  logic [1:0]         word_off,
    input  logic [3:0]         mask,
    input  logic [31:0]        data,
    output logic [BLOCK_W-1:0] block_out
);

    always_comb begin
        block_out = block_in;
        for (int w = 0; w < 4; w++) begin
            for (int b = 0; b < 4; b++) begin
                if ((2'(w) == word_off) && mask[b]) begin
                    block_out[w*32 + b*8 +: 8] = data[b*8 +: 8];
                end
            end
        end
    end

endmodule

// File: rtl/data_cache.sv
// Direct-mapped, write-back, write-allocate data cache between the MEM stage
// and a block-wide backing memory, with saturating hit/miss counters.
module data_cache
    import data_cache_pkg::*;
#(
    parameter int LINE_COUNT = 8,
    parameter int CNT_W      = 16
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic [3:0]         READ_WRITE_EN,
    input  logic [31:0]        ADDRESS,
    input  logic [31:0]        WRITEDATA,
    output logic [31:0]        READDATA,
    output logic               BUSYWAIT,
    output logic               MEM_READ,
    output logic               MEM_WRITE,
    output logic [27:0]        MEM_ADDRESS,
    output logic [BLOCK_W-1:0] MEM_WRITEDATA,
    input  logic [BLOCK_W-1:0] MEM_READDATA,
    input  logic               MEM_BUSYWAIT,
    output logic [CNT_W-1:0]   HIT_COUNT,
    output logic [CNT_W-1:0]   MISS_COUNT
);

    localparam int INDEX_W = $clog2(LINE_COUNT);
    localparam int TAG_W   = 28 - INDEX_W;

    logic [BLOCK_W-1:0]    data_array [LINE_COUNT];
    logic [TAG_W-1:0]      tag_array  [LINE_COUNT];
    logic [LINE_COUNT-1:0] valid;
    logic [LINE_COUNT-1:0] dirty;

    state_t           state;
    logic             replay;
    logic             mem_read_r;
    logic             mem_write_r;
    logic [CNT_W-1:0] hit_cnt;
    logic [CNT_W-1:0] miss_cnt;

    logic [TAG_W-1:0]   addr_tag;
    logic [INDEX_W-1:0] idx;
    logic [1:0]         word_off;
    logic               load_op;
    logic               store_op;
    logic               access;
    logic               hit;
    logic [BLOCK_W-1:0] line_data;
    logic [BLOCK_W-1:0] merged;
    store_lanes_t       lanes;

    assign addr_tag  = ADDRESS[31:4+INDEX_W];
    assign idx       = ADDRESS[3+INDEX_W:4];
    assign word_off  = ADDRESS[3:2];
    assign load_op   = is_load(READ_WRITE_EN);
    assign store_op  = is_store(READ_WRITE_EN);
    assign access    = load_op || store_op;
    assign hit       = valid[idx] && (tag_array[idx] == addr_tag);
    assign line_data = data_array[idx];
    assign lanes     = store_lanes(READ_WRITE_EN, ADDRESS[1:0], WRITEDATA);

    assign READDATA      = line_data[{word_off, 5'b00000} +: 32];
    assign BUSYWAIT      = (access && !hit && (state == ST_IDLE)) || (state != ST_IDLE);
    assign MEM_READ      = mem_read_r;
    assign MEM_WRITE     = mem_write_r;
    assign MEM_ADDRESS   = (state == ST_WRITEBACK) ? {tag_array[idx], idx} : ADDRESS[31:4];
    assign MEM_WRITEDATA = line_data;
    assign HIT_COUNT     = hit_cnt;
    assign MISS_COUNT    = miss_cnt;

    cache_store_merge u_merge (
        .block_in  (line_data),
        .word_off  (word_off),
        .mask      (lanes.mask),
        .data      (lanes.data),
        .block_out (merged)
    );

    // Control state: FSM, line status bits, memory requests and counters.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state       <= ST_IDLE;
            valid       <= '0;
            dirty       <= '0;
            replay      <= 1'b0;
            mem_read_r  <= 1'b0;
            mem_write_r <= 1'b0;
            hit_cnt     <= '0;
            miss_cnt    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    replay <= 1'b0;
                    if (access) begin
                        if (hit) begin
                            if (!replay && (hit_cnt != '1)) hit_cnt <= hit_cnt + CNT_W'(1);
                            if (store_op) dirty[idx] <= 1'b1;
                        end else begin
                            if (miss_cnt != '1) miss_cnt <= miss_cnt + CNT_W'(1);
                            if (valid[idx] && dirty[idx]) begin
                                state       <= ST_WRITEBACK;
                                mem_write_r <= 1'b1;
                            end else begin
                                state      <= ST_FETCH;
                                mem_read_r <= 1'b1;
                            end
                        end
                    end
                end
                ST_WRITEBACK: begin
                    if (!MEM_BUSYWAIT) begin
                        state       <= ST_FETCH;
                        mem_write_r <= 1'b0;
                        mem_read_r  <= 1'b1;
                    end
                end
                ST_FETCH: begin
                    if (!MEM_BUSYWAIT) begin
                        state      <= ST_REFILL;
                        mem_read_r <= 1'b0;
                        valid[idx] <= 1'b1;
                        dirty[idx] <= 1'b0;
                    end
                end
                default: begin
                    // The access replays in IDLE as a hit that must not be counted.
                    state  <= ST_IDLE;
                    replay <= 1'b1;
                end
            endcase
        end
    end

    // Data and tag arrays carry no reset; valid bits guard them.
    always_ff @(posedge CLK) begin
        if ((state == ST_FETCH) && !MEM_BUSYWAIT) begin
            data_array[idx] <= MEM_READDATA;
            tag_array[idx]  <= addr_tag;
        end else if ((state == ST_IDLE) && store_op && hit) begin
            data_array[idx] <= merged;
        end
    end

endmodule

// File: tb/tb_data_cache.sv
// Directed bench for data_cache with a three-cycle block memory model.
module tb_data_cache;
    import data_cache_pkg::*;

    logic         clk;
    logic         rst_n;
    logic [3:0]   rw_en;
    logic [31:0]  address;
    logic [31:0]  wdata;
    logic [31:0]  readdata;
    logic         busywait;
    logic         mem_read;
    logic         mem_write;
    logic [27:0]  mem_address;
    logic [127:0] mem_wdata;
    logic [127:0] mem_rdata;
    logic         mem_busy;
    logic [3:0]   hit_count;
    logic [3:0]   miss_count;

    int total = 0;
    int bad   = 0;

    // Results captured by do_access.
    int           busy_n;
    logic         saw_rd, saw_wr, overlap, wr_before_rd, timed_out;
    logic [27:0]  rd_addr, wr_addr;
    logic [127:0] wr_data;
    logic [31:0]  rdata;

    logic         tb_init;
    logic [127:0] mem [16];
    int           req_cnt;

    data_cache #(.LINE_COUNT(8), .CNT_W(4)) dut (
        .CLK           (clk),
        .RESET         (rst_n),
        .READ_WRITE_EN (rw_en),
        .ADDRESS       (address),
        .WRITEDATA     (wdata),
        .READDATA      (readdata),
        .BUSYWAIT      (busywait),
        .MEM_READ      (mem_read),
        .MEM_WRITE     (mem_write),
        .MEM_ADDRESS   (mem_address),
        .MEM_WRITEDATA (mem_wdata),
        .MEM_READDATA  (mem_rdata),
        .MEM_BUSYWAIT  (mem_busy),
        .HIT_COUNT     (hit_count),
        .MISS_COUNT    (miss_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Each request completes on its third cycle.
    assign mem_busy  = !((mem_read || mem_write) && (req_cnt == 2));
    assign mem_rdata = mem[mem_address[3:0]];

    always @(posedge clk) begin
        if ((mem_read || mem_write) && !mem_busy) req_cnt <= 0;
        else if (mem_read || mem_write)           req_cnt <= req_cnt + 1;
        else                                      req_cnt <= 0;
    end

    always @(posedge clk) begin
        if (tb_init) begin
            for (int i = 0; i < 16; i++) begin
                if (i == 4) mem[i] <= {32'd4, 32'd3, 32'd2, 32'd1};
                else        mem[i] <= {32'(i*16+4), 32'(i*16+3), 32'(i*16+2), 32'(i*16+1)};
            end
        end else if (mem_write && !mem_busy) begin
            mem[mem_address[3:0]] <= mem_wdata;
        end
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one access at a negedge and follow it until BUSYWAIT drops.
    task automatic do_access(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wd);
        int n;
        rw_en = op; address = addr; wdata = wd;
        busy_n = 0; saw_rd = 0; saw_wr = 0; overlap = 0; wr_before_rd = 0;
        rd_addr = '0; wr_addr = '0; wr_data = '0;
        n = 0;
        #1;
        while (busywait && n < 60) begin
            busy_n++;
            if (mem_read && !saw_rd) begin
                rd_addr = mem_address;
                wr_before_rd = saw_wr;
                saw_rd = 1;
            end
            if (mem_write && !saw_wr) begin
                wr_addr = mem_address;
                wr_data = mem_wdata;
                saw_wr = 1;
            end
            if (mem_read && mem_write) overlap = 1;
            @(negedge clk); #1;
            n++;
        end
        timed_out = (n >= 60);
        check("access_timeout", timed_out, 0);
        rdata = readdata;
        @(negedge clk);
        rw_en = IDLE_OP;
        #1;
    endtask

    initial begin
        int n;
        rst_n = 1'b1; tb_init = 1'b1;
        rw_en = IDLE_OP; address = 32'h0; wdata = 32'h0;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        tb_init = 1'b0;
        #1;
        check("rst_mem_read", mem_read, 0);
        check("rst_mem_write", mem_write, 0);
        check("rst_hit", hit_count, 0);
        check("rst_miss", miss_count, 0);
        check("rst_busy", busywait, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Cold miss, clean victim.
        do_access(LW, 32'h0000_0040, 32'h0);
        check("m1_busy", busy_n, 5);
        check("m1_saw_rd", saw_rd, 1);
        check("m1_rd_addr", rd_addr, 28'h4);
        check("m1_saw_wr", saw_wr, 0);
        check("m1_rdata", rdata, 32'd1);
        check("m1_miss", miss_count, 1);
        check("m1_hit", hit_count, 0);

        do_access(LW, 32'h0000_0044, 32'h0);
        check("h1_busy", busy_n, 0);
        check("h1_rdata", rdata, 32'd2);
        check("h1_hit", hit_count, 1);

        do_access(SB, 32'h0000_0046, 32'h0000_00AB);
        check("sb_busy", busy_n, 0);
        check("sb_hit", hit_count, 2);
        do_access(LW, 32'h0000_0044, 32'h0);
        check("sb_rdata", rdata, 32'h00AB_0002);
        check("sb_no_rd", saw_rd, 0);
        check("sb_no_wr", saw_wr, 0);
        check("sb_hit2", hit_count, 3);

        // Conflict miss with dirty victim.
        do_access(LW, 32'h0000_00C0, 32'h0);
        check("wb_busy", busy_n, 8);
        check("wb_saw_wr", saw_wr, 1);
        check("wb_addr", wr_addr, 28'h4);
        check("wb_data", wr_data, {32'd4, 32'd3, 32'h00AB_0002, 32'd1});
        check("wb_rd_addr", rd_addr, 28'hC);
        check("wb_order", wr_before_rd, 1);
        check("wb_overlap", overlap, 0);
        check("wb_rdata", rdata, 32'hC1);
        check("wb_miss", miss_count, 2);
        check("wb_hit", hit_count, 3);

        // Async reset in the middle of a fetch.
        rw_en = LW; address = 32'h0000_0040;
        n = 0;
        do begin
            @(negedge clk); #1;
            n++;
        end while (!mem_read && n < 20);
        check("fr_fetch_seen", mem_read, 1);
        #2 rst_n = 1'b0;
        #1;
        check("fr_mem_read", mem_read, 0);
        check("fr_mem_write", mem_write, 0);
        check("fr_busy", busywait, 1);
        check("fr_hit", hit_count, 0);
        check("fr_miss", miss_count, 0);
        @(negedge clk);
        rw_en = IDLE_OP;
        #1;
        check("fr_idle_busy", busywait, 0);
        @(negedge clk);
        rst_n = 1'b1;

        do_access(LW, 32'h0000_0044, 32'h0);
        check("ar_busy", busy_n, 5);
        check("ar_rd_addr", rd_addr, 28'h4);
        check("ar_rdata", rdata, 32'h00AB_0002);
        check("ar_miss", miss_count, 1);
        check("ar_hit", hit_count, 0);

        // Back-to-back hits drive the 4-bit counter into saturation.
        @(negedge clk);
        rw_en = LW; address = 32'h0000_0044;
        #1;
        check("sat_busy", busywait, 0);
        repeat (15) @(negedge clk);
        #1;
        check("sat_hit15", hit_count, 4'hF);
        repeat (6) @(negedge clk);
        #1;
        check("sat_hit21", hit_count, 4'hF);
        check("sat_miss", miss_count, 1);
        rw_en = IDLE_OP;

        // Remaining store widths and an unused access code.
        @(negedge clk);
        do_access(SH, 32'h0000_004A, 32'hFFFF_1234);
        check("sh_busy", busy_n, 0);
        do_access(LW, 32'h0000_0048, 32'h0);
        check("sh_rdata", rdata, 32'h1234_0003);
        do_access(SW, 32'h0000_004D, 32'hDEAD_BEEF);
        do_access(LBU, 32'h0000_004C, 32'h0);
        check("sw_rdata", rdata, 32'hDEAD_BEEF);
        rw_en = 4'b0111; address = 32'h0000_0200;
        #1;
        check("bad_op_busy", busywait, 0);
        @(negedge clk);
        #1;
        check("bad_op_no_rd", mem_read, 0);
        rw_en = IDLE_OP;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
